rf_port_master: RTL and testbench
=================================

# rf_port_master

Command-driven initiator for the 32-entry, 2-read/1-write register file: it is the block that drives the register file's write and read ports. It accepts one operation at a time over a valid/ready command channel: read pair, write, clear-all sweep, or register-to-register copy. It sequences the register-file port signals cycle by cycle and returns exactly one response per command over a valid/ready response channel. It sits between the control/debug bus logic and the register file, and is the only agent allowed to drive the register-file ports.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; depth is 2**ADDR_W
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  operation: 00 READ, 01 WRITE, 10 CLEAR, 11 COPY
- cmd_addr_a  in  ADDR_W  READ port-1 address / WRITE target / COPY source
- cmd_addr_b  in  ADDR_W  READ port-2 address / COPY destination
- cmd_data  in  DATA_W  WRITE data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data1  out  DATA_W  READ port-1 data / WRITE echo / COPY moved value / 0 for CLEAR
- rsp_data2  out  DATA_W  READ port-2 data, else 0
- rsp_err  out  1  command illegal in this build
- rf_we  out  1  register-file write enable
- rf_write_addr  out  ADDR_W  register-file write index
- rf_write_data  out  DATA_W  register-file write data
- rf_read_addr1, rf_read_addr2  out  ADDR_W  register-file read indices
- rf_read_data1, rf_read_data2  in  DATA_W  register-file combinational read data

## Operation
- FSM states: IDLE, RD, WR, CLR, CP_RD, CP_WR, RESP.
- IDLE: cmd_ready=1. Handshake cmd_valid&&cmd_ready latches op, addresses and data.
- Next state from IDLE by op:
  - READ → RD
  - WRITE → WR
  - CLEAR → CLR with sweep counter=0
  - COPY → CP_RD
- All non-IDLE states hold cmd_ready=0.
- RD: rf_read_addr1=addr_a, rf_read_addr2=addr_b. Capture rf_read_data1/2 into response registers at end of cycle. Next state RESP.
- WR: rf_we=1, rf_write_addr=addr_a, rf_write_data=data. Response data1=data, data2=0. Next state RESP.
- CLR: rf_we=1, rf_write_addr=counter, rf_write_data=0. Counter increments each cycle. After address 2**ADDR_W-1 is written, next state is RESP. The counter wraps to 0 and does not continue.
- CP_RD: rf_read_addr1=addr_a. Capture rf_read_data1 into the hold register. Next state CP_WR.
- CP_WR: rf_we=1, rf_write_addr=addr_b, rf_write_data=hold. Response data1=hold. Next state RESP.
- COPY with addr_a==addr_b is legal; it rewrites the same value.
- RESP: rsp_valid=1 with outputs stable until rsp_ready. On handshake go to IDLE. cmd_ready stays 0 in RESP, so there is no command/response overlap.
- rf_we is 1 only in WR, CLR and CP_WR, and is forced 0 combinationally in any cycle where rst=1.
- When not in use, read addresses drive 0, write address 0, write data 0.

## Timing
- Reset values:
  - state IDLE, cmd_ready=1
  - rsp_valid=0, rsp_data1=0, rsp_data2=0, rsp_err=0
  - rf_we=0, all rf address and data outputs 0
  - sweep counter 0
- rst mid-operation: abandons the command with no response. A CLEAR in progress stops, with entries above the counter untouched.
- Cycle numbering: the command handshake edge ends cycle 0.
  - READ: RD in cycle 1; rsp_valid from cycle 2.
  - WRITE: rf_we in cycle 1, register updated at end of cycle 1; rsp_valid from cycle 2.
  - CLEAR: rf_we in cycles 1..32; rsp_valid from cycle 33.
  - COPY: read in cycle 1, write in cycle 2; rsp_valid from cycle 3.
- Back-to-back throughput: the next command is accepted in the cycle after the response handshake (IDLE cycle).

## Configuration
- RF_MASTER_COPY_EN defined: COPY operates as above.
- Undefined:
  - CP_RD and CP_WR states are not built.
  - A COPY command goes IDLE → RESP directly with rsp_err=1, rsp_data1=0, rsp_data2=0 and no register-file activity. rsp_valid rises in cycle 1.
  - rsp_err is 0 for all other ops in both builds.

## Structure
- Shared package rf_pkg:
  - op enum (RF_OP_READ/WRITE/CLEAR/COPY, 2 bits)
  - FSM state enum
  - RF_DATA_W=32, RF_ADDR_W=5
- Single module, no sub-module. The sweep counter and hold register are inline.
- The bench instantiates this block driving the existing register file.

## Test plan
- WRITE addr_a=5 data=0xDEADBEEF, then READ a=5 b=0 → rsp_data1=0xDEADBEEF, rsp_data2=0, rsp_err=0; READ rsp_valid two cycles after handshake.
- CLEAR after writing 0x1 to regs 0, 17 and 31 → rf_we high exactly 32 consecutive cycles, addresses 0..31; subsequent READ 17/31 returns 0/0.
- COPY a=3 b=9 with reg3=0x12345678 (COPY_EN defined) → reg9=0x12345678, rsp_data1=0x12345678, rsp_valid in cycle 3. Same command with macro undefined → rsp_err=1, reg9 unchanged, no rf_we.
- rsp_ready held low 10 cycles after READ → rsp_valid and data stable, cmd_ready=0 throughout; command offered meanwhile is not accepted until after the RESP handshake.
- rst asserted at CLEAR sweep cycle 10 → rf_we=0 in the reset cycle, state IDLE, rsp_valid=0, cmd_ready=1 next cycle, no response issued.
- Back-to-back WRITE 31=0xFFFFFFFF, READ a=31 b=31 with rsp_ready tied 1 → both ports return 0xFFFFFFFF.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file port master.
//   RF_DATA_W / RF_ADDR_W : register width and index width (32 entries).
//   rf_op_t               : command opcode carried on cmd_op.
//   rf_state_t            : rf_port_master FSM encoding. The copy states only
//                           exist when RF_MASTER_COPY_EN is defined.
`timescale 1ns/1ps

package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        RF_OP_READ  = 2'b00,
        RF_OP_WRITE = 2'b01,
        RF_OP_CLEAR = 2'b10,
        RF_OP_COPY  = 2'b11
    } rf_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_CLR   = 3'd3,
        ST_RESP  = 3'd4
`ifdef RF_MASTER_COPY_EN
        ,
        ST_CP_RD = 3'd5,
        ST_CP_WR = 3'd6
`endif
    } rf_state_t;

endpackage

// File: rtl/rf_port_master.sv
// rf_port_master: single command/response initiator that owns the ports of
// the 32-entry 2R/1W register file.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op selects READ/WRITE/CLEAR/COPY
//   cmd_addr_a/b        read addresses, write target, copy source/destination
//   cmd_data            write data
//   rsp_valid/ready     response handshake, one response per command
//   rsp_data1/2, rsp_err response payload
//   rf_we, rf_write_*   register-file write port
//   rf_read_addr1/2     register-file read indices
//   rf_read_data1/2     register-file combinational read data
//
// Build option: RF_MASTER_COPY_EN enables the COPY operation. Without it a
// COPY command is answered at once with rsp_err=1 and touches nothing.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | cmd_ready=1, waiting for a command
// ST_RD    | drive both read addresses, capture read data
// ST_WR    | single write of cmd_data to addr_a
// ST_CLR   | zero sweep, one entry per cycle, counter 0..31
// ST_CP_RD | copy: read source into hold register
// ST_CP_WR | copy: write hold register to destination
// ST_RESP  | rsp_valid=1 until rsp_ready
`timescale 1ns/1ps

module rf_port_master
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rsp_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    rf_state_t         state;
    rf_state_t         state_nx;
    rf_op_t            op_in;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] rsp_data1_q;
    logic [DATA_W-1:0] rsp_data2_q;
    logic              rsp_err_q;
    logic              we_c;
`ifdef RF_MASTER_COPY_EN
    logic [DATA_W-1:0] hold_q;
`endif

    assign op_in = rf_op_t'(cmd_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_q      <= '0;
            cnt         <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef RF_MASTER_COPY_EN
            hold_q      <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_a_q    <= cmd_addr_a;
                        addr_b_q    <= cmd_addr_b;
                        data_q      <= cmd_data;
                        cnt         <= '0;
                        // Response payload starts at zero; each state fills
                        // in only the fields its operation returns.
                        rsp_data1_q <= '0;
                        rsp_data2_q <= '0;
`ifdef RF_MASTER_COPY_EN
                        rsp_err_q   <= 1'b0;
`else
                        rsp_err_q   <= (op_in == RF_OP_COPY);
`endif
                    end
                end
                ST_RD: begin
                    rsp_data1_q <= rf_read_data1;
                    rsp_data2_q <= rf_read_data2;
                end
                ST_WR: begin
                    rsp_data1_q <= data_q;
                end
                ST_CLR: begin
                    cnt <= cnt + 1'b1;
                end
`ifdef RF_MASTER_COPY_EN
                ST_CP_RD: begin
                    hold_q <= rf_read_data1;
                end
                ST_CP_WR: begin
                    rsp_data1_q <= hold_q;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx      = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        we_c          = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        rf_read_addr1 = '0;
        rf_read_addr2 = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op_in)
                        RF_OP_READ:  state_nx = ST_RD;
                        RF_OP_WRITE: state_nx = ST_WR;
                        RF_OP_CLEAR: state_nx = ST_CLR;
`ifdef RF_MASTER_COPY_EN
                        RF_OP_COPY:  state_nx = ST_CP_RD;
`else
                        RF_OP_COPY:  state_nx = ST_RESP;
`endif
                        default:     state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_RD: begin
                rf_read_addr1 = addr_a_q;
                rf_read_addr2 = addr_b_q;
                state_nx      = ST_RESP;
            end
            ST_WR: begin
                we_c          = 1'b1;
                rf_write_addr = addr_a_q;
                rf_write_data = data_q;
                state_nx      = ST_RESP;
            end
            ST_CLR: begin
                we_c          = 1'b1;
                rf_write_addr = cnt;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nx = ST_RESP;
                end
            end
`ifdef RF_MASTER_COPY_EN
            ST_CP_RD: begin
                rf_read_addr1 = addr_a_q;
                state_nx      = ST_CP_WR;
            end
            ST_CP_WR: begin
                we_c          = 1'b1;
                rf_write_addr = addr_b_q;
                rf_write_data = hold_q;
                state_nx      = ST_RESP;
            end
`endif
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Reset is synchronous, so the state register still shows the old state
    // during the reset cycle; the write strobe must be killed directly.
    assign rf_we     = we_c & ~rst;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rf_port_master.sv
`timescale 1ns/1ps

module tb_rf_port_master;
    import rf_pkg::*;

    localparam int DW    = RF_DATA_W;
    localparam int AW    = RF_ADDR_W;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          rsp_err;
    logic          rf_we;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rf_read_addr1;
    logic [AW-1:0] rf_read_addr2;
    logic [DW-1:0] rf_read_data1;
    logic [DW-1:0] rf_read_data2;

    always #5 clk = ~clk;

    rf_port_master dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr_a    (cmd_addr_a),
        .cmd_addr_b    (cmd_addr_b),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2),
        .rsp_err       (rsp_err),
        .rf_we         (rf_we),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    // Register file driven by the DUT, with a bench-only preload port.
    logic [DW-1:0] rf_mem [DEPTH];
    logic          init_we = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [DW-1:0] init_data = '0;

    always @(posedge clk) begin
        if (init_we) rf_mem[init_addr] <= init_data;
        else if (rf_we) rf_mem[rf_write_addr] <= rf_write_data;
    end
    assign rf_read_data1 = rf_mem[rf_read_addr1];
    assign rf_read_data2 = rf_mem[rf_read_addr2];

    // Command-level reference: expected register contents.
    logic [DW-1:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    // Applies one command to the reference and returns the expected response,
    // cycle of first rsp_valid after the handshake, and number of writes.
    task automatic model(input rf_op_t op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, output logic [DW-1:0] e1, output logic [DW-1:0] e2,
                         output logic eerr, output int elat, output int ewr);
        e1 = '0; e2 = '0; eerr = 1'b0;
        case (op)
            RF_OP_READ:  begin e1 = ref_mem[a]; e2 = ref_mem[b]; elat = 2; ewr = 0; end
            RF_OP_WRITE: begin ref_mem[a] = d; e1 = d; elat = 2; ewr = 1; end
            RF_OP_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                elat = DEPTH + 1; ewr = DEPTH;
            end
            default: begin
`ifdef RF_MASTER_COPY_EN
                e1 = ref_mem[a]; ref_mem[b] = e1; elat = 3; ewr = 1;
`else
                eerr = 1'b1; elat = 1; ewr = 0;
`endif
            end
        endcase
    endtask

    // Offers a command from the current (post-edge) time; returns the number of
    // cycles spent waiting for cmd_ready. Leaves time in cycle 1 of the command.
    task automatic issue(input rf_op_t op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, output int waited);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_addr_q.delete(); wr_data_q.delete();
    endtask

    // Watches from cycle 1 until rsp_valid (bounded), logging every write.
    task automatic wait_rsp(output int lat);
        lat = 1;
        if (rf_we) begin wr_addr_q.push_back(rf_write_addr); wr_data_q.push_back(rf_write_data); end
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (rf_we) begin wr_addr_q.push_back(rf_write_addr); wr_data_q.push_back(rf_write_data); end
        end
    endtask

    task automatic run_cmd(input rf_op_t op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [DW-1:0] d, output int waited, output int lat);
        issue(op, a, b, d, waited);
        wait_rsp(lat);
    endtask

    task automatic test_reset();
        logic we_seen;
        we_seen = 1'b0;
        rst = 1'b1; init_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            init_addr = AW'(i); init_data = $urandom; ref_mem[i] = init_data;
            @(posedge clk); #1;
            if (rf_we) we_seen = 1'b1;
        end
        init_we = 1'b0;
        n_checks++; if (we_seen !== 1'b0) begin n_errors++; $display("FAIL reset_we_held got=%b exp=0", we_seen); end
        rst = 1'b0; #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== '0) begin n_errors++; $display("FAIL reset_rsp got=%h/%h/%b exp=0", rsp_data1, rsp_data2, rsp_err); end
        n_checks++; if ({rf_we, rf_write_addr, rf_write_data, rf_read_addr1, rf_read_addr2} !== '0) begin
            n_errors++; $display("FAIL reset_rf_ports got=%b/%h/%h/%h/%h exp=0", rf_we, rf_write_addr, rf_write_data, rf_read_addr1, rf_read_addr2);
        end
    endtask

    task automatic test_write_read();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew;
        model(RF_OP_WRITE, 5'd0, 5'd0, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd0, 5'd0, 32'h0, w, lat);
        model(RF_OP_WRITE, 5'd5, 5'd0, 32'hDEADBEEF, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd5, 5'd0, 32'hDEADBEEF, w, lat);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        n_checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 5'd5 || wr_data_q[0] !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL wr_port got_writes=%0d exp=1 at 5=deadbeef", wr_addr_q.size());
        end
        n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== {32'hDEADBEEF, 32'h0, 1'b0}) begin
            n_errors++; $display("FAIL wr_rsp got=%h/%h/%b exp=deadbeef/0/0", rsp_data1, rsp_data2, rsp_err);
        end
        model(RF_OP_READ, 5'd5, 5'd0, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_READ, 5'd5, 5'd0, 32'h0, w, lat);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== {32'hDEADBEEF, 32'h0, 1'b0}) begin
            n_errors++; $display("FAIL rd_rsp got=%h/%h/%b exp=deadbeef/0/0", rsp_data1, rsp_data2, rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew;
        rsp_ready = 1'b1;
        model(RF_OP_WRITE, 5'd31, 5'd0, 32'hFFFFFFFF, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd31, 5'd0, 32'hFFFFFFFF, w, lat);
        model(RF_OP_READ, 5'd31, 5'd31, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_READ, 5'd31, 5'd31, 32'h0, w, lat);
        n_checks++; if (w !== 1) begin n_errors++; $display("FAIL b2b_accept_wait got=%0d exp=1", w); end
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        n_checks++; if ({rsp_data1, rsp_data2} !== {2{32'hFFFFFFFF}}) begin
            n_errors++; $display("FAIL b2b_rsp got=%h/%h exp=ffffffff/ffffffff", rsp_data1, rsp_data2);
        end
    endtask

    task automatic test_copy();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew;
        model(RF_OP_WRITE, 5'd3, 5'd0, 32'h12345678, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd3, 5'd0, 32'h12345678, w, lat);
        model(RF_OP_WRITE, 5'd9, 5'd0, 32'hA5A5A5A5, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd9, 5'd0, 32'hA5A5A5A5, w, lat);
        model(RF_OP_COPY, 5'd3, 5'd9, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_COPY, 5'd3, 5'd9, 32'h0, w, lat);
`ifdef RF_MASTER_COPY_EN
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL copy_latency got=%0d exp=3", lat); end
        n_checks++; if ({rsp_data1, rsp_err} !== {32'h12345678, 1'b0}) begin
            n_errors++; $display("FAIL copy_rsp got=%h/%b exp=12345678/0", rsp_data1, rsp_err);
        end
        n_checks++; if (rf_mem[9] !== 32'h12345678) begin n_errors++; $display("FAIL copy_dest got=%h exp=12345678", rf_mem[9]); end
`else
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL copy_off_latency got=%0d exp=1", lat); end
        n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== {64'h0, 1'b1}) begin
            n_errors++; $display("FAIL copy_off_rsp got=%h/%h/%b exp=0/0/1", rsp_data1, rsp_data2, rsp_err);
        end
        n_checks++; if (rf_mem[9] !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL copy_off_dest got=%h exp=a5a5a5a5", rf_mem[9]); end
`endif
        n_checks++; if (wr_addr_q.size() != ew) begin n_errors++; $display("FAIL copy_writes got=%0d exp=%0d", wr_addr_q.size(), ew); end
        model(RF_OP_COPY, 5'd3, 5'd3, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_COPY, 5'd3, 5'd3, 32'h0, w, lat);
        n_checks++; if (rf_mem[3] !== 32'h12345678 || lat !== el || rsp_err !== ee) begin
            n_errors++; $display("FAIL copy_same got=%h/%0d/%b exp=12345678/%0d/%b", rf_mem[3], lat, rsp_err, el, ee);
        end
    endtask

    task automatic test_stall();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew;
        logic bad; logic [AW-1:0] a, b; logic [DW-1:0] d;
        a = AW'($urandom); b = AW'($urandom); d = $urandom;
        model(RF_OP_READ, a, b, 32'h0, e1, e2, ee, el, ew);
        issue(RF_OP_READ, a, b, 32'h0, w);
        rsp_ready = 1'b0;
        wait_rsp(lat);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL stall_latency got=%0d exp=2", lat); end
        cmd_valid = 1'b1; cmd_op = RF_OP_WRITE; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data1 !== e1 || rsp_data2 !== e2 || cmd_ready !== 1'b0 || rf_we !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL stall_hold got=%b/%h/%h/%b exp=1/%h/%h/0", rsp_valid, rsp_data1, rsp_data2, cmd_ready, e1, e2); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_errors++; $display("FAIL stall_release got=%b%b exp=01", rsp_valid, cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_addr_q.delete(); wr_data_q.delete();
        model(RF_OP_WRITE, a, b, d, e1, e2, ee, el, ew);
        wait_rsp(lat);
        n_checks++; if (lat !== 2 || wr_addr_q.size() != 1 || rf_mem[a] !== d) begin
            n_errors++; $display("FAIL stall_late_write got=%0d/%0d/%h exp=2/1/%h", lat, wr_addr_q.size(), rf_mem[a], d);
        end
    endtask

    task automatic test_random();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew;
        int sel; rf_op_t op; logic [AW-1:0] a, b; logic [DW-1:0] d; logic mem_bad;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? RF_OP_READ : (sel < 7) ? RF_OP_WRITE : (sel < 9) ? RF_OP_COPY : RF_OP_CLEAR;
            a = AW'($urandom); b = AW'($urandom); d = $urandom;
            model(op, a, b, d, e1, e2, ee, el, ew);
            run_cmd(op, a, b, d, w, lat);
            n_checks++; if (w > 1 || lat !== el || wr_addr_q.size() != ew) begin
                n_errors++; $display("FAIL rand_timing op=%0d got=%0d/%0d/%0d exp<=1/%0d/%0d", op, w, lat, wr_addr_q.size(), el, ew);
            end
            n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== {e1, e2, ee}) begin
                n_errors++; $display("FAIL rand_rsp op=%0d got=%h/%h/%b exp=%h/%h/%b", op, rsp_data1, rsp_data2, rsp_err, e1, e2, ee);
            end
        end
        mem_bad = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (rf_mem[i] !== ref_mem[i]) mem_bad = 1'b1;
        n_checks++; if (mem_bad !== 1'b0) begin n_errors++; $display("FAIL rand_mem got=differs exp=reference"); end
    endtask

    task automatic test_reset_mid_clear();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew; logic bad;
        model(RF_OP_WRITE, 5'd8, 5'd0, 32'h11111111, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd8, 5'd0, 32'h11111111, w, lat);
        model(RF_OP_WRITE, 5'd9, 5'd0, 32'h22222222, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd9, 5'd0, 32'h22222222, w, lat);
        model(RF_OP_WRITE, 5'd31, 5'd0, 32'h33333333, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd31, 5'd0, 32'h33333333, w, lat);
        issue(RF_OP_CLEAR, 5'd0, 5'd0, 32'h0, w);
        for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
        // Sweep cycles 1..9 have written entries 0..8; reset lands in cycle 10.
        for (int i = 0; i < 9; i++) ref_mem[i] = '0;
        rst = 1'b1; #1;
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL rstclr_we got=%b exp=0", rf_we); end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_checks++; if ({cmd_ready, rsp_valid, rf_we} !== 3'b100) begin
            n_errors++; $display("FAIL rstclr_idle got=%b%b%b exp=100", cmd_ready, rsp_valid, rf_we);
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid || rf_we) bad = 1'b1; end
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL rstclr_no_rsp got=1 exp=0"); end
        n_checks++; if ({rf_mem[8], rf_mem[9], rf_mem[31]} !== {32'h0, 32'h22222222, 32'h33333333}) begin
            n_errors++; $display("FAIL rstclr_mem got=%h/%h/%h exp=0/22222222/33333333", rf_mem[8], rf_mem[9], rf_mem[31]);
        end
        bad = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (rf_mem[i] !== ref_mem[i]) bad = 1'b1;
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL rstclr_mem_all got=differs exp=reference"); end
    endtask

    task automatic test_clear();
        int w, lat; logic [DW-1:0] e1, e2; logic ee; int el, ew; logic bad;
        model(RF_OP_WRITE, 5'd0, 5'd0, 32'h1, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd0, 5'd0, 32'h1, w, lat);
        model(RF_OP_WRITE, 5'd17, 5'd0, 32'h1, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd17, 5'd0, 32'h1, w, lat);
        model(RF_OP_WRITE, 5'd31, 5'd0, 32'h1, e1, e2, ee, el, ew);
        run_cmd(RF_OP_WRITE, 5'd31, 5'd0, 32'h1, w, lat);
        model(RF_OP_CLEAR, 5'd0, 5'd0, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_CLEAR, 5'd0, 5'd0, 32'h0, w, lat);
        n_checks++; if (lat !== 33) begin n_errors++; $display("FAIL clr_latency got=%0d exp=33", lat); end
        bad = (wr_addr_q.size() != DEPTH);
        for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== '0) bad = 1'b1;
        n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL clr_sweep got_writes=%0d exp=32 zeros at 0..31", wr_addr_q.size()); end
        n_checks++; if ({rsp_data1, rsp_data2, rsp_err} !== '0) begin n_errors++; $display("FAIL clr_rsp got=%h/%h/%b exp=0", rsp_data1, rsp_data2, rsp_err); end
        model(RF_OP_READ, 5'd17, 5'd31, 32'h0, e1, e2, ee, el, ew);
        run_cmd(RF_OP_READ, 5'd17, 5'd31, 32'h0, w, lat);
        n_checks++; if ({rsp_data1, rsp_data2} !== 64'h0) begin n_errors++; $display("FAIL clr_readback got=%h/%h exp=0/0", rsp_data1, rsp_data2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_copy();
        test_stall();
        test_random();
        test_reset_mid_clear();
        test_clear();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
